fll_cfg_responder: RTL



---
 rtl/fll_cfg_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fll_cfg_responder.sv
// FLL-side configuration bus responder: req/ack handshake, register bank and lock model.
// Lock drops on any cfg1/cfg2 write and re-asserts LOCK_CYCLES after the last such write.
module fll_cfg_responder #(
  parameter int unsigned ACK_LATENCY = 2,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [31:0] CFG1_RST    = 32'h0000_0100,
  parameter logic [31:0] CFG2_RST    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fll_req_i,
  input  logic        fll_wrn_i,
  input  logic [1:0]  fll_add_i,
  input  logic [31:0] fll_data_i,
  output logic        fll_ack_o,
  output logic [31:0] fll_r_data_o,
  output logic        fll_lock_o
);

  // state     | meaning
  // ST_IDLE   | no transaction, waiting for req
  // ST_WAIT   | request captured, counting down to ack
  // ST_ACK    | ack cycle, access committed
  // ST_RELEASE| waiting for the initiator to drop req
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_RELEASE} state_e;

  localparam logic [3:0]  WAIT_INIT = 4'(ACK_LATENCY - 1);
  localparam logic [15:0] LOCK_INIT = 16'(LOCK_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        wrn_q;
  logic [1:0]  add_q;
  logic [31:0] data_q;
  logic [31:0] cfg1_q, cfg2_q, integ_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        lock_q;
  logic [15:0] lcnt_q;
  logic        capture, commit, relock;
  logic [31:0] rd_val;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fll_req_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!fll_req_i)        state_d = ST_IDLE;
        else if (wcnt_q == '0) state_d = ST_ACK;
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (!fll_req_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == ST_IDLE) && fll_req_i;
    commit  = (state_q == ST_WAIT) && fll_req_i && (wcnt_q == '0);
    relock  = commit && !wrn_q && ((add_q == 2'd1) || (add_q == 2'd2));
    wcnt_d  = wcnt_q;
    if (capture)                                   wcnt_d = WAIT_INIT;
    else if (state_q == ST_WAIT && wcnt_q != '0)   wcnt_d = wcnt_q - 4'd1;
    case (add_q)
      2'd0:    rd_val = {lock_q, 15'b0, cfg1_q[15:0]};
      2'd1:    rd_val = cfg1_q;
      2'd2:    rd_val = cfg2_q;
      default: rd_val = integ_q;
    endcase
    rdata_d = wrn_q ? rd_val : 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q  <= '0;
      wrn_q   <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      ack_q  <= commit;
      if (capture) begin
        wrn_q  <= fll_wrn_i;
        add_q  <= fll_add_i;
        data_q <= fll_data_i;
      end
      if (commit) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg1_q  <= CFG1_RST;
      cfg2_q  <= CFG2_RST;
      integ_q <= '0;
    end else if (commit && !wrn_q) begin
      case (add_q)
        2'd1:    cfg1_q  <= data_q;
        2'd2:    cfg2_q  <= data_q;
        2'd3:    integ_q <= data_q;
        default: ;
      endcase
    end
  end

  // Counter saturates at zero; lock rises on the edge it gets there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lcnt_q <= LOCK_INIT;
      lock_q <= 1'b0;
    end else if (relock) begin
      lcnt_q <= LOCK_INIT;
      lock_q <= 1'b0;
    end else if (lcnt_q != '0) begin
      lcnt_q <= lcnt_q - 16'd1;
      if (lcnt_q == 16'd1) lock_q <= 1'b1;
    end
  end

  assign fll_ack_o    = ack_q;
  assign fll_r_data_o = rdata_q;
  assign fll_lock_o   = lock_q;

endmodule
